// File: rtl/spi_accel_poller.sv
// -----------------------------------------------------------------------------
// spi_accel_poller
//
// Sequencer for an SPI accelerometer (ADXL345 register map by default) that
// drives a 16-bit spi_master through a command stream and a response stream.
// After enable it writes the init registers, reads DEVID and checks it (with
// a bounded number of whole-sequence retries), then reads NUM_AXES 16-bit axis
// registers every SAMPLE_PERIOD cycles and presents one packed sample on an
// AXI-Stream style output.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   enable          level; sequencer runs while high
//   cmd_t*          SPI word {rw, mb=0, addr[5:0], data[7:0]} to spi_master
//   rsp_t*          full-duplex response word from spi_master, data in [7:0]
//   out_t*          packed sample {axis N-1 .. axis 0}, each {hi,lo}; tlast = 1
//   configured      DEVID verified, polling active
//   failed          retries exhausted; sticky until reset
//   overrun_count   saturating count of poll ticks lost while a sample waited
//
// Handshakes: every stream uses valid/ready. A beat transfers on a clock edge
// where valid and ready are both high. Once valid is raised, data and valid are
// held unchanged until that edge. Exactly one SPI transfer is outstanding at a
// time: cmd_tvalid is held until cmd_tready, then rsp_tready is held high until
// one response beat is taken. Writes consume a response beat as well.
// -----------------------------------------------------------------------------
module spi_accel_poller #(
  parameter int         NUM_AXES          = 3,
  parameter logic [5:0] DATA_BASE_ADDR    = 6'h32,
  parameter logic [7:0] DEVID_EXPECTED    = 8'hE5,
  parameter logic [7:0] POWER_CTL_VALUE   = 8'h08,
  parameter logic [7:0] DATA_FORMAT_VALUE = 8'h00,
  parameter int         SAMPLE_PERIOD     = 100000,
  parameter int         RSP_TIMEOUT       = 4096,
  parameter int         MAX_RETRIES       = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic [15:0]             cmd_tdata,
  output logic                    cmd_tvalid,
  input  logic                    cmd_tready,
  input  logic [15:0]             rsp_tdata,
  input  logic                    rsp_tvalid,
  output logic                    rsp_tready,
  output logic [16*NUM_AXES-1:0]  out_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tlast,
  output logic                    configured,
  output logic                    failed,
  output logic [15:0]             overrun_count
);

  localparam int SW    = 16 * NUM_AXES;
  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int TO_W  = $clog2(RSP_TIMEOUT + 1);
  localparam int RT_W  = $clog2(MAX_RETRIES + 2);

  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RSP_TIMEOUT - 1);
  localparam logic [RT_W-1:0]  RT_MAX    = RT_W'(MAX_RETRIES);
  localparam logic [2:0]       LAST_INIT = 3'd3;
  localparam logic [2:0]       LAST_READ = 3'(2 * NUM_AXES - 1);
  localparam logic [15:0]      ID_WORD   = {2'b10, 6'h00, 8'h00};

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_ID_ISSUE,
    S_ID_WAIT,
    S_ID_CHECK,
    S_POLL_WAIT_TICK,
    S_POLL_ISSUE,
    S_POLL_WAIT,
    S_OUTPUT,
    S_FAILED
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [15:0]       cmd_tdata_q, cmd_tdata_d;
  logic              cmd_tvalid_q, cmd_tvalid_d;
  logic              rsp_tready_q, rsp_tready_d;
  logic [SW-1:0]     out_tdata_q, out_tdata_d;
  logic              out_tvalid_q, out_tvalid_d;
  logic [SW-1:0]     sample_q, sample_d;
  logic [7:0]        id_byte_q, id_byte_d;
  logic              configured_q, configured_d;
  logic              failed_q, failed_d;
  logic [15:0]       overrun_q, overrun_d;
  logic [RT_W-1:0]   retry_q, retry_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [PER_W-1:0]  period_q, period_d;

  logic tick, timeout, cmd_fire, rsp_fire;
  logic start_init, go_idle, retry_go;

  // Upper response byte carries nothing for this sequencer.
  logic unused_rsp_hi;
  assign unused_rsp_hi = ^rsp_tdata[15:8];

  assign tick     = configured_q && (period_q == PER_LAST);
  assign timeout  = (wait_q == TO_LAST);
  assign cmd_fire = cmd_tvalid_q && cmd_tready;
  assign rsp_fire = rsp_tvalid && rsp_tready_q;

  // Init writes in order: POWER_CTL, DATA_FORMAT, INT_ENABLE=0, FIFO_CTL=0.
  function automatic logic [15:0] init_word(input logic [2:0] i);
    case (i)
      3'd0:    return {2'b00, 6'h2D, POWER_CTL_VALUE};
      3'd1:    return {2'b00, 6'h31, DATA_FORMAT_VALUE};
      3'd2:    return {2'b00, 6'h2E, 8'h00};
      default: return {2'b00, 6'h38, 8'h00};
    endcase
  endfunction

  // Poll read i targets DATA_BASE_ADDR + i (axis i/2, lo byte when i even).
  function automatic logic [15:0] poll_word(input logic [2:0] i);
    logic [5:0] a;
    a = DATA_BASE_ADDR + {3'b000, i};
    return {2'b10, a, 8'h00};
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cmd_tdata_d  = cmd_tdata_q;
    cmd_tvalid_d = cmd_tvalid_q;
    rsp_tready_d = rsp_tready_q;
    out_tdata_d  = out_tdata_q;
    out_tvalid_d = out_tvalid_q;
    sample_d     = sample_q;
    id_byte_d    = id_byte_q;
    configured_d = configured_q;
    failed_d     = failed_q;
    overrun_d    = overrun_q;
    retry_d      = retry_q;
    wait_d       = wait_q;
    // Period counter only advances while configured; parked at 0 otherwise.
    period_d     = configured_q ? (tick ? '0 : period_q + 1'b1) : '0;
    start_init   = 1'b0;
    go_idle      = 1'b0;
    retry_go     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          retry_d    = '0;
          start_init = 1'b1;
        end
      end

      S_INIT_ISSUE: begin
        if (cmd_fire) begin
          cmd_tvalid_d = 1'b0;
          rsp_tready_d = 1'b1;
          wait_d       = '0;
          state_d      = S_INIT_WAIT;
        end
      end

      S_INIT_WAIT: begin
        if (rsp_fire) begin
          rsp_tready_d = 1'b0;
          if (!enable) begin
            go_idle = 1'b1;
          end else if (idx_q == LAST_INIT) begin
            state_d      = S_ID_ISSUE;
            cmd_tdata_d  = ID_WORD;
            cmd_tvalid_d = 1'b1;
          end else begin
            idx_d        = idx_q + 3'd1;
            state_d      = S_INIT_ISSUE;
            cmd_tdata_d  = init_word(idx_q + 3'd1);
            cmd_tvalid_d = 1'b1;
          end
        end else if (timeout) begin
          if (!enable) go_idle = 1'b1;
          else         retry_go = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_ID_ISSUE: begin
        if (cmd_fire) begin
          cmd_tvalid_d = 1'b0;
          rsp_tready_d = 1'b1;
          wait_d       = '0;
          state_d      = S_ID_WAIT;
        end
      end

      S_ID_WAIT: begin
        if (rsp_fire) begin
          rsp_tready_d = 1'b0;
          if (!enable) begin
            go_idle = 1'b1;
          end else begin
            id_byte_d = rsp_tdata[7:0];
            state_d   = S_ID_CHECK;
          end
        end else if (timeout) begin
          if (!enable) go_idle = 1'b1;
          else         retry_go = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_ID_CHECK: begin
        if (!enable) begin
          go_idle = 1'b1;
        end else if (id_byte_q == DEVID_EXPECTED) begin
          configured_d = 1'b1;
          retry_d      = '0;
          period_d     = '0;
          state_d      = S_POLL_WAIT_TICK;
        end else begin
          retry_go = 1'b1;
        end
      end

      S_POLL_WAIT_TICK: begin
        if (!enable) begin
          go_idle = 1'b1;
        end else if (tick) begin
          idx_d        = 3'd0;
          sample_d     = '0;
          state_d      = S_POLL_ISSUE;
          cmd_tdata_d  = poll_word(3'd0);
          cmd_tvalid_d = 1'b1;
        end
      end

      S_POLL_ISSUE: begin
        if (cmd_fire) begin
          cmd_tvalid_d = 1'b0;
          rsp_tready_d = 1'b1;
          wait_d       = '0;
          state_d      = S_POLL_WAIT;
        end
      end

      S_POLL_WAIT: begin
        if (rsp_fire) begin
          rsp_tready_d = 1'b0;
          // Byte lane i of the sample is register BASE+i.
          sample_d[{idx_q, 3'b000} +: 8] = rsp_tdata[7:0];
          if (!enable) begin
            go_idle = 1'b1;
          end else if (idx_q == LAST_READ) begin
            out_tdata_d  = sample_d;
            out_tvalid_d = 1'b1;
            state_d      = S_OUTPUT;
          end else begin
            idx_d        = idx_q + 3'd1;
            state_d      = S_POLL_ISSUE;
            cmd_tdata_d  = poll_word(idx_q + 3'd1);
            cmd_tvalid_d = 1'b1;
          end
        end else if (timeout) begin
          if (!enable) go_idle = 1'b1;
          else         retry_go = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_OUTPUT: begin
        if (out_tready) begin
          out_tvalid_d = 1'b0;
          state_d      = enable ? S_POLL_WAIT_TICK : S_IDLE;
          if (!enable) go_idle = 1'b1;
        end else if (!enable) begin
          go_idle = 1'b1;
        end else if (tick && (overrun_q != 16'hFFFF)) begin
          // The held sample is not replaced; the lost poll is only counted.
          overrun_d = overrun_q + 16'd1;
        end
      end

      S_FAILED: begin
        // Terminal until reset; enable is ignored.
      end

      default: state_d = S_IDLE;
    endcase

    if (go_idle) begin
      state_d      = S_IDLE;
      configured_d = 1'b0;
      out_tvalid_d = 1'b0;
      cmd_tvalid_d = 1'b0;
      rsp_tready_d = 1'b0;
    end

    // A failed attempt abandons any transfer and partial sample.
    if (retry_go) begin
      configured_d = 1'b0;
      out_tvalid_d = 1'b0;
      rsp_tready_d = 1'b0;
      retry_d      = retry_q + 1'b1;
      if (retry_q >= RT_MAX) begin
        state_d      = S_FAILED;
        failed_d     = 1'b1;
        cmd_tvalid_d = 1'b0;
      end else begin
        start_init = 1'b1;
      end
    end

    if (start_init) begin
      state_d      = S_INIT_ISSUE;
      idx_d        = 3'd0;
      cmd_tdata_d  = init_word(3'd0);
      cmd_tvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cmd_tdata_q  <= '0;
      cmd_tvalid_q <= 1'b0;
      rsp_tready_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      sample_q     <= '0;
      id_byte_q    <= '0;
      configured_q <= 1'b0;
      failed_q     <= 1'b0;
      overrun_q    <= '0;
      retry_q      <= '0;
      wait_q       <= '0;
      period_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cmd_tdata_q  <= cmd_tdata_d;
      cmd_tvalid_q <= cmd_tvalid_d;
      rsp_tready_q <= rsp_tready_d;
      out_tdata_q  <= out_tdata_d;
      out_tvalid_q <= out_tvalid_d;
      sample_q     <= sample_d;
      id_byte_q    <= id_byte_d;
      configured_q <= configured_d;
      failed_q     <= failed_d;
      overrun_q    <= overrun_d;
      retry_q      <= retry_d;
      wait_q       <= wait_d;
      period_q     <= period_d;
    end
  end

  assign cmd_tdata     = cmd_tdata_q;
  assign cmd_tvalid    = cmd_tvalid_q;
  assign rsp_tready    = rsp_tready_q;
  assign out_tdata     = out_tdata_q;
  assign out_tvalid    = out_tvalid_q;
  assign out_tlast     = 1'b1;
  assign configured    = configured_q;
  assign failed        = failed_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_spi_accel_poller.sv
// -----------------------------------------------------------------------------
// tb_spi_accel_poller
//
// Bench for spi_accel_poller with a short sample period and response timeout.
// A negedge-driven SPI device model answers commands from a register array;
// expected command words and output samples are queued by the directed steps
// and popped when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_spi_accel_poller;

  localparam int P  = 200;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [15:0] rsp_tdata;
  logic        rsp_tvalid;
  logic        rsp_tready;
  logic [47:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;
  logic        configured;
  logic        failed;
  logic [15:0] overrun_count;

  spi_accel_poller #(
    .NUM_AXES      (3),
    .SAMPLE_PERIOD (P),
    .RSP_TIMEOUT   (TO),
    .MAX_RETRIES   (3)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .enable        (enable),
    .cmd_tdata     (cmd_tdata),
    .cmd_tvalid    (cmd_tvalid),
    .cmd_tready    (cmd_tready),
    .rsp_tdata     (rsp_tdata),
    .rsp_tvalid    (rsp_tvalid),
    .rsp_tready    (rsp_tready),
    .out_tdata     (out_tdata),
    .out_tvalid    (out_tvalid),
    .out_tready    (out_tready),
    .out_tlast     (out_tlast),
    .configured    (configured),
    .failed        (failed),
    .overrun_count (overrun_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_cmd_q[$];
  logic [47:0] exp_out_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- SPI device model ----------------
  logic [7:0]  regs [64];
  logic [5:0]  drop_addr = 6'h00;
  bit          drop_en = 0;
  bit          drop_seen = 0;
  bit          busy = 0;
  bit          rsp_taken = 0;
  int          lat = 0;
  logic [15:0] rsp_word = '0;
  int          devid_reads = 0;
  int          out_beats = 0;

  task automatic slave_cmd(input logic [15:0] w);
    if (exp_cmd_q.size() == 0) chk("cmd_extra", cmd_tvalid, 0);
    else                       chk("cmd_word", w, exp_cmd_q.pop_front());
    if (w == 16'h8000) devid_reads++;
    if (w[15] && drop_en && (w[13:8] == drop_addr)) begin
      drop_en   = 0;
      drop_seen = 1;
    end else begin
      if (!w[15]) regs[w[13:8]] = w[7:0];
      busy     = 1;
      lat      = $urandom_range(0, 3);
      rsp_word = {8'($urandom_range(0, 255)), (w[15] ? regs[w[13:8]] : 8'h00)};
    end
  endtask

  // Drives device-side inputs at negedge; every handshake evaluated here
  // completes at the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      cmd_tready = 0;
      rsp_tvalid = 0;
      busy       = 0;
      rsp_taken  = 0;
    end else begin
      if (rsp_taken) begin
        rsp_tvalid = 0;
        busy       = 0;
        rsp_taken  = 0;
      end else if (busy && !rsp_tvalid) begin
        if (lat == 0) begin
          rsp_tvalid = 1;
          rsp_tdata  = rsp_word;
        end else begin
          lat--;
        end
      end
      cmd_tready = !busy && ($urandom_range(0, 3) != 0);
      if (cmd_tvalid && cmd_tready) slave_cmd(cmd_tdata);
      if (rsp_tvalid && rsp_tready) rsp_taken = 1;
      if (out_tvalid && out_tready) begin
        out_beats++;
        if (exp_out_q.size() == 0) chk("out_extra", out_tvalid, 0);
        else                       chk("out_tdata", out_tdata, exp_out_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_init();
    exp_cmd_q.push_back(16'h2D08);
    exp_cmd_q.push_back(16'h3100);
    exp_cmd_q.push_back(16'h2E00);
    exp_cmd_q.push_back(16'h3800);
    exp_cmd_q.push_back(16'h8000);
  endtask

  task automatic push_poll();
    exp_cmd_q.push_back(16'hB200);
    exp_cmd_q.push_back(16'hB300);
    exp_cmd_q.push_back(16'hB400);
    exp_cmd_q.push_back(16'hB500);
    exp_cmd_q.push_back(16'hB600);
    exp_cmd_q.push_back(16'hB700);
  endtask

  function automatic logic [47:0] cur_sample();
    return {regs[6'h37], regs[6'h36], regs[6'h35], regs[6'h34], regs[6'h33], regs[6'h32]};
  endfunction

  task automatic randomize_axes();
    for (int i = 0; i < 6; i++) regs[6'h32 + i] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_drained(input int bound, input string tag);
    int n = 0;
    while ((exp_cmd_q.size() + exp_out_q.size()) != 0 && n < bound) begin
      step(1);
      n++;
    end
    chk(tag, exp_cmd_q.size() + exp_out_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_tvalid"}, cmd_tvalid, 0);
    chk({tag, "_cmd_tdata"}, cmd_tdata, 0);
    chk({tag, "_rsp_tready"}, rsp_tready, 0);
    chk({tag, "_out_tvalid"}, out_tvalid, 0);
    chk({tag, "_out_tdata"}, out_tdata, 0);
    chk({tag, "_out_tlast"}, out_tlast, 1);
    chk({tag, "_configured"}, configured, 0);
    chk({tag, "_failed"}, failed, 0);
    chk({tag, "_overrun"}, overrun_count, 0);
  endtask

  // ---------------- directed steps ----------------
  initial begin
    int n;
    int beats0;
    logic [47:0] held;

    rst        = 1;
    enable     = 0;
    out_tready = 1;
    rsp_tdata  = '0;
    for (int i = 0; i < 64; i++) regs[i] = 8'h00;

    // Reset state
    step(3);
    check_reset_outputs("reset");

    // Init sequence, DEVID check and first sample with the documented bytes
    regs[6'h00] = 8'hE5;
    regs[6'h32] = 8'h34; regs[6'h33] = 8'h12;
    regs[6'h34] = 8'h78; regs[6'h35] = 8'h56;
    regs[6'h36] = 8'hBC; regs[6'h37] = 8'h9A;
    push_init();
    push_poll();
    exp_out_q.push_back(48'h9ABC_5678_1234);
    rst = 0;
    step(2);
    enable = 1;
    n = 0;
    while (configured !== 1'b1 && n < 1000) begin step(1); n++; end
    chk("configured_up", configured, 1);
    wait_drained(3 * P, "sample1_done");
    chk("overrun_idle", overrun_count, 0);

    // Second sample with random axis bytes
    randomize_axes();
    push_poll();
    exp_out_q.push_back(cur_sample());
    wait_drained(3 * P, "sample2_done");

    // Hold the output for 3.5 periods
    randomize_axes();
    held = cur_sample();
    push_poll();
    exp_out_q.push_back(held);
    out_tready = 0;
    n = 0;
    while (out_tvalid !== 1'b1 && n < 3 * P) begin step(1); n++; end
    chk("out_held", out_tvalid, 1);
    step(P * 7 / 2);
    chk("overrun_count", overrun_count, 3);
    chk("held_valid", out_tvalid, 1);
    chk("held_data", out_tdata, held);
    beats0 = out_beats;
    out_tready = 1;
    step(1);
    chk("held_delivered", out_beats - beats0, 1);
    chk("held_queue", exp_out_q.size(), 0);

    // Dropped response on the second poll read
    drop_addr = 6'h33;
    drop_seen = 0;
    drop_en   = 1;
    beats0    = out_beats;
    exp_cmd_q.push_back(16'hB200);
    exp_cmd_q.push_back(16'hB300);
    push_init();
    push_poll();
    exp_out_q.push_back(held);
    n = 0;
    while (!drop_seen && n < 3 * P) begin step(1); n++; end
    chk("drop_seen", drop_seen, 1);
    n = 0;
    while (configured === 1'b1 && n < 4 * TO) begin step(1); n++; end
    chk("timeout_cycles", n, TO);
    chk("timeout_unconfigured", configured, 0);
    wait_drained(4 * P, "recover_done");
    chk("recover_configured", configured, 1);
    chk("recover_one_beat", out_beats - beats0, 1);

    // Reset asserted while a poll read is outstanding
    drop_addr = 6'h32;
    drop_seen = 0;
    drop_en   = 1;
    exp_cmd_q.push_back(16'hB200);
    n = 0;
    while (!drop_seen && n < 3 * P) begin step(1); n++; end
    chk("poll_read_seen", drop_seen, 1);
    step(2);
    chk("in_poll_wait", rsp_tready, 1);
    rst = 1;
    #1;
    check_reset_outputs("midreset");
    step(2);
    drop_en = 0;
    randomize_axes();
    push_init();
    push_poll();
    exp_out_q.push_back(cur_sample());
    rst = 0;
    wait_drained(4 * P, "reinit_done");
    chk("reinit_configured", configured, 1);

    // DEVID mismatch on every attempt
    rst    = 1;
    enable = 0;
    step(2);
    regs[6'h00] = 8'h00;
    devid_reads = 0;
    for (int a = 0; a < 4; a++) push_init();
    rst = 0;
    step(1);
    enable = 1;
    n = 0;
    while (failed !== 1'b1 && n < 3000) begin step(1); n++; end
    chk("failed_set", failed, 1);
    chk("failed_unconfigured", configured, 0);
    chk("failed_cmd_idle", cmd_tvalid, 0);
    chk("devid_reads", devid_reads, 4);
    enable = 0;
    step(50);
    enable = 1;
    step(300);
    chk("failed_sticky", failed, 1);
    chk("failed_no_more_cmds", exp_cmd_q.size(), 0);
    chk("devid_reads_final", devid_reads, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
